// File: rtl/gelato_ram_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters one outstanding read at a time on a shared RAM port.
// Grant is a same-cycle strobe from IDLE; the response strobe follows ram_rsp_valid by one cycle; rdy=0 freezes everything.
module gelato_ram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      ram_req_valid,
  output logic [ADDR_W-1:0]         ram_req_addr,
  input  logic                      ram_req_ready,
  input  logic                      ram_rsp_valid,
  input  logic [DATA_W-1:0]         ram_rsp_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last_grant, owner, winner, idx;
  logic              any_req;
  logic [ADDR_W-1:0] win_addr;

  // Search starts just after the last served requester and wraps around.
  always_comb begin
    any_req  = 1'b0;
    winner   = last_grant;
    idx      = '0;
    win_addr = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) win_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    ram_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ISSUE;
          // The accept strobe must not leak out while frozen or held in reset.
          if (rdy && rst_n) req_ready = ONE << winner;
        end
      end
      ISSUE: begin
        ram_req_valid = 1'b1;
        if (ram_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (ram_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= LAST_RST;
      owner        <= '0;
      ram_req_addr <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
    end else if (rdy) begin
      state     <= state_nxt;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner        <= winner;
            ram_req_addr <= win_addr;
          end
        end
        WAIT: begin
          if (ram_rsp_valid) begin
            rsp_data   <= ram_rsp_data;
            rsp_valid  <= ONE << owner;
            last_grant <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gelato_ram_arbiter.md
GELATO_RAM_ARBITER -- requirements
Module: gelato_ram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing the RAM port (2..4).
REQ-002 Parameter ADDR_W, default 32: request address width.
REQ-003 Parameter DATA_W, default 32: read data width.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 Port rdy  in  1: global enable; when low, all state and outputs hold.
REQ-007 Port req_valid  in  NUM_REQ: per-requester read request.
REQ-008 Port req_addr  in  NUM_REQ*ADDR_W: per-requester address; slice i at bits [i*ADDR_W +: ADDR_W].
REQ-009 Port req_ready  out  NUM_REQ: one-hot request accept strobe.
REQ-010 Port rsp_valid  out  NUM_REQ: one-hot response strobe to the owning requester.
REQ-011 Port rsp_data  out  DATA_W: response data, shared by all requesters.
REQ-012 Port ram_req_valid  out  1: RAM request valid.
REQ-013 Port ram_req_addr  out  ADDR_W: RAM request address.
REQ-014 Port ram_req_ready  in  1: RAM accepts request.
REQ-015 Port ram_rsp_valid  in  1: RAM response valid, one cycle per response.
REQ-016 Port ram_rsp_data  in  DATA_W: RAM response data.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT; only one transaction outstanding at a time.
REQ-018 IDLE: if any req_valid is high, grant the round-robin winner: assert req_ready[winner] for exactly that cycle, latch winner index and address, go to ISSUE.
REQ-019 Round-robin: search starts at (last_grant+1) mod NUM_REQ, increasing index, with wrap-around; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-020 ISSUE: ram_req_valid=1 with the latched address; on ram_req_ready=1, go to WAIT; the address SHALL stay stable while ram_req_valid is high and ready is low.
REQ-021 WAIT: on ram_rsp_valid=1, register ram_rsp_data into rsp_data, pulse rsp_valid[owner] for one cycle the next cycle, update last_grant=owner, and go to IDLE.
REQ-022 Latency: grant in cycle T; ram_req_valid from T+1; response strobe the cycle after ram_rsp_valid; the next grant no earlier than the rsp_valid cycle.
REQ-023 ram_rsp_valid outside WAIT SHALL be ignored; req_valid outside IDLE SHALL not be granted, and the request is held by the requester.
REQ-024 rsp_data SHALL hold its last value while rsp_valid is low.
REQ-025 While rdy=0, no transitions, latches or strobe changes SHALL occur; an incoming ram_rsp_valid during rdy=0 is dropped; the system guarantees it does not occur.
REQ-026 req_ready and rsp_valid SHALL each be one-hot or zero in every cycle.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, last_grant=NUM_REQ-1, req_ready=0, rsp_valid=0, rsp_data=0, ram_req_valid=0, ram_req_addr=0.
REQ-028 Reset mid-transaction SHALL abandon it with no rsp_valid; after release, the block restarts from IDLE.

Verification
REQ-029 Single request: req_valid=01, addr0=0x100, ram ready immediately, response 0xDEAD two cycles later -> req_ready=01 one cycle, ram_req_addr=0x100, rsp_valid=01 with rsp_data=0xDEAD.
REQ-030 Contention: both requesters hold valid for 4 transactions -> grant order 0,1,0,1, each response routed to the matching rsp_valid bit.
REQ-031 Backpressure: ram_req_ready low 5 cycles in ISSUE -> ram_req_valid and addr stable for all 5 cycles, exactly one handshake.
REQ-032 Stall: rdy low 3 cycles during WAIT, then ram_rsp_valid -> state held, response delivered after rdy returns, with no duplicate.
REQ-033 Spurious response: ram_rsp_valid pulse in IDLE -> no rsp_valid, state remains IDLE.
REQ-034 Reset in WAIT -> all outputs 0 immediately; the next request after release is granted to requester 0 first.
